tt_nand_selftest: RTL and testbench

- On-chip stimulus generator and response checker for the NAND project. It is the driving/checking end of the pin interface that the top-level NAND design consumes.
- Sweeps every input combination of a WIDTH-gate two-input NAND array, compares each DUT response against the expected ~(a & b), and reports pass/fail, a mismatch count and the first failing vector.
- Sits beside the NAND core inside the tt_um wrapper. Intended outputs: stimulus to the core inputs, status to uo_out.

---
 rtl/tt_nand_selftest.sv | 195 +++++++++++++++++++
 tb/tb_tt_nand_selftest.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/tt_nand_selftest.sv
// rtl/tt_nand_selftest.sv - exhaustive stimulus/response self-test for a WIDTH-gate NAND array (optional: NAND_SELFTEST_STOP_ON_FAIL_EN)
module tt_nand_selftest #(
  parameter int WIDTH    = 4,
  parameter int RESP_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               start,
  input  logic [WIDTH-1:0]   resp,
  output logic [WIDTH-1:0]   stim_a,
  output logic [WIDTH-1:0]   stim_b,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [7:0]         err_count,
  output logic               first_fail_valid,
  output logic [2*WIDTH-1:0] first_fail_vec
);

  localparam int VW = 2 * WIDTH;
  localparam logic [VW-1:0] LAST_VEC = '1;
  localparam logic [VW-1:0] VEC_ONE  = {{(VW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [VW-1:0] stim_q, stim_d;

  // Stage 0 is written alongside the stimulus; stage RESP_LAT-1 is compared.
  logic [RESP_LAT-1:0]                vld_q, vld_d;
  logic [RESP_LAT-1:0][WIDTH-1:0]     exp_q, exp_d;
  logic [RESP_LAT-1:0][VW-1:0]        vec_q, vec_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [7:0]    err_q, err_d;
  logic          ffv_q, ffv_d;
  logic [VW-1:0] ffvec_q, ffvec_d;

  logic          cmp_valid;
  logic          mismatch;
  logic [VW-1:0] stim_inc;

  function automatic logic [WIDTH-1:0] nand_of(input logic [VW-1:0] v);
    return ~(v[VW-1:WIDTH] & v[WIDTH-1:0]);
  endfunction

  assign cmp_valid = vld_q[RESP_LAT-1];
  assign mismatch  = cmp_valid && (resp != exp_q[RESP_LAT-1]);
  assign stim_inc  = stim_q + VEC_ONE;

  // State register; reset aborts any sweep in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and status registers, all driven from the next-state logic below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim_q  <= '0;
      vld_q   <= '0;
      exp_q   <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
    end else begin
      stim_q  <= stim_d;
      vld_q   <= vld_d;
      exp_q   <= exp_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
    end
  end

  // Next-state: everything holds while ena is low, otherwise shift, compare and sequence.
  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    vld_d   = vld_q;
    exp_d   = exp_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;

    if (ena) begin
      for (int i = RESP_LAT - 1; i > 0; i--) begin
        vld_d[i] = vld_q[i-1];
        exp_d[i] = exp_q[i-1];
        vec_d[i] = vec_q[i-1];
      end
      vld_d[0] = 1'b0;
      exp_d[0] = '0;
      vec_d[0] = '0;

      if (mismatch) begin
        if (err_q != 8'hFF) begin
          err_d = err_q + 8'd1;
        end
        if (!ffv_q) begin
          ffv_d   = 1'b1;
          ffvec_d = vec_q[RESP_LAT-1];
        end
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d  = S_RUN;
            stim_d   = '0;
            vld_d[0] = 1'b1;
            vec_d[0] = '0;
            exp_d[0] = nand_of('0);
            err_d    = '0;
            ffv_d    = 1'b0;
            ffvec_d  = '0;
            busy_d   = 1'b1;
            done_d   = 1'b0;
            pass_d   = 1'b0;
          end
        end
        S_RUN: begin
          stim_d   = stim_inc;
          vld_d[0] = 1'b1;
          vec_d[0] = stim_inc;
          exp_d[0] = nand_of(stim_inc);
          if (stim_inc == LAST_VEC) begin
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          stim_d = '0;
          // The final vector reaching the compare stage empties the pipeline.
          if (cmp_valid && (vec_q[RESP_LAT-1] == LAST_VEC)) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == 8'd0);
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

`ifdef NAND_SELFTEST_STOP_ON_FAIL_EN
      // First mismatch ends the sweep; in-flight vectors are dropped.
      if (mismatch && ((state_q == S_RUN) || (state_q == S_DRAIN))) begin
        state_d = S_DONE;
        stim_d  = '0;
        vld_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = 1'b0;
      end
`else
      // Full sweep always runs; every mismatch is counted above.
`endif
    end
  end

  assign stim_a           = stim_q[VW-1:WIDTH];
  assign stim_b           = stim_q[WIDTH-1:0];
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_tt_nand_selftest.sv
// tb/tb_tt_nand_selftest.sv - self-checking bench for tt_nand_selftest
module tb_tt_nand_selftest;

  localparam int W = 4;
  localparam int N = 256;

  logic clk = 1'b0;
  logic rst_n, ena, start;
  logic [W-1:0] fm, fv;

  logic [W-1:0] a1, b1, resp1, ffv_dummy1;
  logic         busy1, done1, pass1, ffv1;
  logic [7:0]   err1;
  logic [2*W-1:0] ffvec1;

  logic [W-1:0] a2, b2, resp2;
  logic         busy2, done2, pass2, ffv2;
  logic [7:0]   err2;
  logic [2*W-1:0] ffvec2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Combinational NAND array with an optional stuck-at fault mask.
  assign resp1 = (~(a1 & b1) & ~fm) | (fv & fm);
  assign ffv_dummy1 = '0;

  // Registered, fault-free NAND array sharing the design enable.
  always @(posedge clk) begin
    if (ena) resp2 <= ~(a2 & b2);
  end

  tt_nand_selftest #(.WIDTH(W), .RESP_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .resp(resp1),
    .stim_a(a1), .stim_b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail_valid(ffv1), .first_fail_vec(ffvec1)
  );

  tt_nand_selftest #(.WIDTH(W), .RESP_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .resp(resp2),
    .stim_a(a2), .stim_b(b2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_fail_valid(ffv2), .first_fail_vec(ffvec2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: enumerate all vectors, count faulty responses, derive done time.
  task automatic model(input logic [W-1:0] m, input logic [W-1:0] v, input int lat,
                       output int err, output bit any, output int first, output int done_k);
    logic [W-1:0] a, b, good, got;
    int mism;
    mism = 0; any = 0; first = 0;
    for (int x = 0; x < N; x++) begin
      a = x[7:4];
      b = x[3:0];
      good = ~(a & b);
      got = (good & ~m) | (v & m);
      if (got != good) begin
        if (!any) begin any = 1; first = x; end
        mism++;
      end
    end
    err = (mism > 255) ? 255 : mism;
    done_k = N - 1 + lat;
`ifdef NAND_SELFTEST_STOP_ON_FAIL_EN
    if (any) begin err = 1; done_k = first + lat; end
`endif
  endtask

  task automatic run_sweep(input string tag, input logic [W-1:0] m, input logic [W-1:0] v,
                           input int pause_at, input bit pulse);
    int e1, f1, d1, e2, f2, d2, x1, x2, got1, got2, stim_exp;
    bit any1, any2;
    model(m, v, 1, e1, any1, f1, d1);
    model('0, '0, 2, e2, any2, f2, d2);
    stim_exp = (pause_at < d1) ? pause_at : 0;
    x1 = d1; x2 = d2;
    if (pause_at >= 0 && pause_at < d1) x1 = d1 + 10;
    if (pause_at >= 0 && pause_at < d2) x2 = d2 + 10;
    fm = m; fv = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy_at_e0"}, 32'(busy1), 32'd1);
    chk({tag, " stim_at_e0"}, 32'({a1, b1}), 32'd0);
    got1 = -1; got2 = -1;
    for (int k = 0; k < 400; k++) begin
      if (got1 < 0 && done1) got1 = k;
      if (got2 < 0 && done2) got2 = k;
      if (got1 >= 0 && got2 >= 0) break;
      if (pause_at >= 0 && k == pause_at) ena = 1'b0;
      if (pause_at >= 0 && k == pause_at + 10) begin
        chk({tag, " stim_held_in_pause"}, 32'({a1, b1}), 32'(stim_exp));
        ena = 1'b1;
      end
      start = (pulse && pause_at >= 0 && k == pause_at + 20 && k < x1);
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, " done_edge_lat1"}, 32'(got1), 32'(x1));
    chk({tag, " done_edge_lat2"}, 32'(got2), 32'(x2));
    chk({tag, " pass1"}, 32'(pass1), 32'(e1 == 0));
    chk({tag, " err1"}, 32'(err1), 32'(e1));
    chk({tag, " ffv1"}, 32'(ffv1), 32'(any1));
    chk({tag, " ffvec1"}, 32'(ffvec1), 32'(f1));
    chk({tag, " busy1_end"}, 32'(busy1), 32'd0);
    chk({tag, " stim1_end"}, 32'({a1, b1}), 32'd0);
    chk({tag, " lat2_status"}, 32'({pass2, err2, ffv2}), 32'({1'b1, 8'd0, 1'b0}));
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; start = 1'b0; fm = '0; fv = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs1", 32'({a1, b1, busy1, done1, pass1, err1, ffv1, ffvec1}), 32'd0);
    chk("reset_outputs2", 32'({a2, b2, busy2, done2, pass2, err2, ffv2, ffvec2}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // start with ena low must be ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ena_low_ignored", 32'({busy1, busy2}), 32'd0);
    ena = 1'b1;
    @(negedge clk);

    run_sweep("clean", 4'h0, 4'h0, -1, 1'b0);
    run_sweep("stuck0", 4'h1, 4'h1, -1, 1'b0);
    run_sweep("pause64", 4'h0, 4'h0, 64, 1'b1);
    for (int r = 0; r < 3; r++) begin
      run_sweep("random", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                $urandom_range(1, 200), 1'b1);
    end

    // reset in the middle of a faulty sweep
    fm = 4'h1; fv = 4'h1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    chk("mid_sweep_busy", 32'(busy1), 32'd1);
    chk("mid_sweep_stim", 32'({a1, b1}), 32'd100);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs1", 32'({a1, b1, busy1, done1, pass1, err1, ffv1, ffvec1}), 32'd0);
    chk("async_reset_outputs2", 32'({a2, b2, busy2, done2, pass2, err2, ffv2, ffvec2}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_sweep("after_reset", 4'h0, 4'h0, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
